// File: rtl/toi2s_pkg.sv
// rtl/toi2s_pkg.sv - shared types and register-bank field widths for the toi2s PWM path
//
// Contents:
//   pwm_mode_t : PWM_EDGE (0) / PWM_CENTER (1) alignment select
//   RB_PWM_*_W : register-bank field widths for the PWM configuration
//   sys_cfg_t  : system configuration word carried from rb_toi2s
package toi2s_pkg;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_t;

   localparam int PWM_N_CH          = 2;
   localparam int PWM_WIDTH         = 8;
   localparam int PWM_PRESCALE_W    = 4;

   localparam int RB_PWM_MODE_W     = 1;
   localparam int RB_PWM_PRESCALE_W = PWM_PRESCALE_W;
   localparam int RB_PWM_DUTY_W     = PWM_N_CH * PWM_WIDTH;

   typedef struct packed {
      logic                         pwm_ena;
      logic [RB_PWM_MODE_W-1:0]     pwm_mode;
      logic [RB_PWM_PRESCALE_W-1:0] pwm_prescale;
      logic [RB_PWM_DUTY_W-1:0]     pwm_duty;
   } sys_cfg_t;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared prescaler, up/up-down counter and period boundary strobe
//
// Ports:
//   clk, resetb : clock, asynchronous active-low reset
//   ena         : run enable; when low everything is parked at count 0, direction up
//   mode        : requested alignment (pwm_mode_t encoding), latched at each boundary
//   prescale    : requested divider P, latched at each boundary
//   count       : current counter value
//   boundary    : high on the cycle the counter reads 0 at the start of a period
module pwm_timebase
   import toi2s_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  ena,
   input  logic                  mode,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  boundary
);

   // Top counter value M-1 = 2^WIDTH - 2
   localparam logic [WIDTH-1:0] CNT_TOP = {{(WIDTH-1){1'b1}}, 1'b0};

   logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic                  dir_q, dir_d;          // 0 = counting up
   pwm_mode_t             mode_w_q, mode_w_d;
   logic [PRESCALE_W-1:0] presc_w_q, presc_w_d;
   logic                  run_q, run_d;          // ena was high last cycle
   logic                  wrap_q, wrap_d;        // last tick reloaded count 0 going up

   pwm_mode_t             mode_eff;
   logic [PRESCALE_W-1:0] presc_eff;
   logic                  tick;

   // The boundary cycle uses the live inputs so the new working copies
   // govern the whole period that starts here.
   assign boundary  = ena & (~run_q | wrap_q);
   assign mode_eff  = boundary ? pwm_mode_t'(mode) : mode_w_q;
   assign presc_eff = boundary ? prescale : presc_w_q;
   assign tick      = ena & (presc_cnt_q == presc_eff);
   assign count     = count_q;

   always_comb begin
      presc_cnt_d = presc_cnt_q;
      count_d     = count_q;
      dir_d       = dir_q;
      mode_w_d    = mode_w_q;
      presc_w_d   = presc_w_q;
      run_d       = run_q;
      wrap_d      = 1'b0;
      if (!ena) begin
         presc_cnt_d = '0;
         count_d     = '0;
         dir_d       = 1'b0;
         run_d       = 1'b0;
      end else begin
         run_d       = 1'b1;
         mode_w_d    = mode_eff;
         presc_w_d   = presc_eff;
         presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
         if (tick) begin
            if (mode_eff == PWM_EDGE) begin
               dir_d = 1'b0;
               if (count_q == CNT_TOP) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end else if (!dir_q) begin
               // Hold the end value for a second tick while turning around
               if (count_q == CNT_TOP) dir_d = 1'b1;
               else                    count_d = count_q + 1'b1;
            end else begin
               if (count_q == '0) begin
                  dir_d  = 1'b0;
                  wrap_d = 1'b1;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         presc_cnt_q <= '0;
         count_q     <= '0;
         dir_q       <= 1'b0;
         mode_w_q    <= PWM_EDGE;
         presc_w_q   <= '0;
         run_q       <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         presc_cnt_q <= presc_cnt_d;
         count_q     <= count_d;
         dir_q       <= dir_d;
         mode_w_q    <= mode_w_d;
         presc_w_q   <= presc_w_d;
         run_q       <= run_d;
         wrap_q      <= wrap_d;
      end
   end

endmodule

// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - N-channel PWM with shared time base and double-buffered duties
//
// Ports:
//   clk, resetb  : clock, asynchronous active-low reset
//   ena          : run enable
//   mode         : 0 edge-aligned, 1 center-aligned
//   prescale     : time-base divider P
//   duty         : requested duties, channel k at [k*WIDTH +: WIDTH]
//   update_req   : pulse, snapshot duty into the shadow registers
//   update_done  : pulse, shadow values became active
//   period_start : pulse at each period boundary
//   pwm_out      : registered PWM outputs
module pwm_multi_ch
   import toi2s_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   ena,
   input  logic                   mode,
   input  logic [PRESCALE_W-1:0]  prescale,
   input  logic [N_CH*WIDTH-1:0]  duty,
   input  logic                   update_req,
   output logic                   update_done,
   output logic                   period_start,
   output logic [N_CH-1:0]        pwm_out
);

   logic [WIDTH-1:0] count;
   logic             boundary;
   logic             pending_q, pending_d;
   logic             dis_done_q, dis_done_d;
   logic             apply;

   pwm_timebase #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) u_timebase (
      .clk      (clk),
      .resetb   (resetb),
      .ena      (ena),
      .mode     (mode),
      .prescale (prescale),
      .count    (count),
      .boundary (boundary)
   );

   assign apply        = boundary & pending_q;
   assign update_done  = apply | dis_done_q;
   assign period_start = boundary;

   // A request on a boundary cycle re-arms pending after the current shadow
   // has been applied, so the new value waits for the following boundary.
   always_comb begin
      pending_d  = pending_q;
      dis_done_d = ~ena & update_req;
      if (!ena) begin
         if (update_req) pending_d = 1'b0;
      end else if (update_req) begin
         pending_d = 1'b1;
      end else if (apply) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pending_q  <= 1'b0;
         dis_done_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         dis_done_q <= dis_done_d;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [WIDTH-1:0] shadow_q, shadow_d;
      logic [WIDTH-1:0] active_q, active_d;
      logic [WIDTH-1:0] active_eff;
      logic             pwm_q, pwm_d;

      // Compare against the incoming value on the apply cycle so the first
      // count of the new period already uses the new duty.
      always_comb begin
         shadow_d   = shadow_q;
         active_eff = apply ? shadow_q : active_q;
         active_d   = active_eff;
         if (update_req) begin
            shadow_d = duty[k*WIDTH +: WIDTH];
            if (!ena) active_d = duty[k*WIDTH +: WIDTH];
         end
         pwm_d = ena & (count < active_eff);
      end

      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
         end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
         end
      end

      assign pwm_out[k] = pwm_q;
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - self-checking bench for pwm_multi_ch against a period-position model
module tb_pwm_multi_ch;

   localparam int NC = 2;
   localparam int W  = 4;
   localparam int PW = 4;
   localparam int M  = 15;

   logic            clk = 1'b0;
   logic            resetb;
   logic            ena;
   logic            mode;
   logic [PW-1:0]   prescale;
   logic [NC*W-1:0] duty;
   logic            update_req;
   logic            update_done;
   logic            period_start;
   logic [NC-1:0]   pwm_out;

   int errors = 0;
   int checks = 0;

   // model state
   int     t;
   bit     first;
   int     m_mode, m_p;
   int     active[NC];
   int     shadow[NC];
   bit     pending, dis_done;
   bit [NC-1:0] pwm_exp;

   // observed tallies
   int n_ps, n_done, hi0, hi1;

   pwm_multi_ch #(.N_CH(NC), .WIDTH(W), .PRESCALE_W(PW)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .ena          (ena),
      .mode         (mode),
      .prescale     (prescale),
      .duty         (duty),
      .update_req   (update_req),
      .update_done  (update_done),
      .period_start (period_start),
      .pwm_out      (pwm_out)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int plen();
      return (m_mode != 0) ? 2 * M * (m_p + 1) : M * (m_p + 1);
   endfunction

   // Counter value at clock offset tt into the period
   function automatic int cnt_at(input int tt);
      int i;
      i = tt / (m_p + 1);
      if (m_mode == 0) return i;
      return (i < M) ? i : 2 * M - 1 - i;
   endfunction

   function automatic bit next_is_ps();
      return ena && (first || t == plen());
   endfunction

   task automatic model_reset();
      t = 0; first = 1; m_mode = 0; m_p = 0;
      pending = 0; dis_done = 0; pwm_exp = '0;
      for (int k = 0; k < NC; k++) begin
         active[k] = 0;
         shadow[k] = 0;
      end
   endtask

   task automatic set_duty(input int d0, input int d1);
      duty = {4'(d1), 4'(d0)};
   endtask

   // One clock: inputs are already driven; check at negedge, then advance
   task automatic cycle();
      bit ps, done, app;
      int eff;
      bit [NC-1:0] nxt;
      @(negedge clk);
      nxt = '0;
      if (!ena) begin
         ps   = 0;
         done = dis_done;
         dis_done = update_req;
         if (update_req) begin
            for (int k = 0; k < NC; k++) begin
               shadow[k] = int'(duty[k*W +: W]);
               active[k] = shadow[k];
            end
            pending = 0;
         end
         first = 1;
      end else begin
         ps = first || (t == plen());
         if (ps) begin
            t = 0;
            m_mode = int'(mode);
            m_p = int'(prescale);
         end
         app  = ps && pending;
         done = app || dis_done;
         for (int k = 0; k < NC; k++) begin
            eff = app ? shadow[k] : active[k];
            nxt[k] = cnt_at(t) < eff;
            if (app) active[k] = shadow[k];
         end
         if (app) pending = 0;
         if (update_req) begin
            for (int k = 0; k < NC; k++) shadow[k] = int'(duty[k*W +: W]);
            pending = 1;
         end
         dis_done = 0;
         t++;
         first = 0;
      end
      chk("period_start", period_start, ps);
      chk("update_done", update_done, done);
      chk("pwm_out", pwm_out, pwm_exp);
      pwm_exp = nxt;
      n_ps   += int'(period_start);
      n_done += int'(update_done);
      hi0    += int'(pwm_out[0]);
      hi1    += int'(pwm_out[1]);
      @(posedge clk);
      #1;
      update_req = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic align();
      for (int i = 0; i < 400 && !next_is_ps(); i++) cycle();
      chk("align_bound", next_is_ps(), 1);
   endtask

   task automatic clr_tally();
      n_ps = 0; n_done = 0; hi0 = 0; hi1 = 0;
   endtask

   initial begin
      resetb = 1'b0; ena = 1'b0; mode = 1'b0; prescale = '0;
      duty = '0; update_req = 1'b0;
      model_reset();
      clr_tally();
      @(posedge clk);
      #1;
      run(2);
      resetb = 1'b1;
      run(3);

      // disabled update goes straight to active, done the next cycle
      set_duty(5, 15);
      update_req = 1'b1;
      clr_tally();
      run(3);
      chk("dis_done_count", n_done, 1);

      // edge mode, P=0, duties {5,15}
      ena = 1'b1; mode = 1'b0; prescale = 0;
      clr_tally();
      run(45);
      chk("edge_ps_count", n_ps, 3);
      chk("edge_ch0_high", hi0, 15);
      chk("edge_ch1_high", hi1, 44);

      // mid-period update at count 7
      align();
      run(7);
      set_duty(10, 15);
      update_req = 1'b1;
      clr_tally();
      run(8);
      chk("mid_no_done_yet", n_done, 0);
      chk("mid_old_duty_high", hi0, 0);
      clr_tally();
      run(16);
      chk("mid_done_count", n_done, 1);
      chk("mid_new_duty_high", hi0, 10);

      // request on a boundary cycle
      align();
      set_duty(3, 15);
      update_req = 1'b1;
      clr_tally();
      run(1);
      chk("bnd_no_done_now", n_done, 0);
      run(15);
      chk("bnd_done_count", n_done, 1);

      // two requests in one period, last wins
      align();
      run(3);
      clr_tally();
      set_duty(7, 15);
      update_req = 1'b1;
      run(3);
      set_duty(9, 2);
      update_req = 1'b1;
      run(30);
      chk("two_req_done_count", n_done, 1);

      // switch to center mode P=1 mid-period with duties {3,0}
      align();
      run(4);
      mode = 1'b1; prescale = 1;
      set_duty(3, 0);
      update_req = 1'b1;
      run(1);
      align();
      run(1);
      clr_tally();
      run(60);
      chk("ctr_ch0_high", hi0, 12);
      chk("ctr_ch1_high", hi1, 0);
      chk("ctr_ps_count", n_ps, 1);

      // toggle mode back mid-period
      run(17);
      mode = 1'b0;
      run(100);

      // randomized phase
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            for (int k = 0; k < NC; k++) begin
               case ($urandom_range(0, 3))
                  0:       duty[k*W +: W] = '0;
                  1:       duty[k*W +: W] = 4'(M);
                  default: duty[k*W +: W] = 4'($urandom_range(0, M));
               endcase
            end
            update_req = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) prescale = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 79) == 0) ena = ~ena;
         cycle();
      end

      // asynchronous reset mid-period
      ena = 1'b1; mode = 1'b0; prescale = 0;
      set_duty(15, 15);
      update_req = 1'b1;
      run(20);
      #2;
      resetb = 1'b0;
      #1;
      chk("async_rst_pwm", pwm_out, 0);
      chk("async_rst_done", update_done, 0);
      ena = 1'b0;
      model_reset();
      run(2);
      resetb = 1'b1;
      clr_tally();
      run(5);
      chk("post_rst_pwm_high", hi0 + hi1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Parametrised multi-channel PWM generator that replaces the single-channel 8-bit `pwm` block in `toi2s_tt_top`. It drives `N_CH` outputs from one shared time base and supports a programmable prescaler and edge-aligned or center-aligned modes. Duty values are double-buffered and change only on a period boundary, so outputs never glitch. Configuration arrives from `rb_toi2s` register fields; `update_done` is available as a status bit.

## Interface
Parameters:
- `N_CH`, default 2: number of PWM channels.
- `WIDTH`, default 8: duty/counter width. The full-scale value is M = 2^WIDTH − 1.
- `PRESCALE_W`, default 4: prescaler width.

Ports:
- `clk` input, 1: system clock. All logic is in this single domain.
- `resetb` input, 1: asynchronous, active-low reset.
- `ena` input, 1: run enable.
- `mode` input, 1: 0 selects edge-aligned, 1 selects center-aligned.
- `prescale` input, `PRESCALE_W`: time-base divider value P.
- `duty` input, `N_CH*WIDTH`: requested duties. Channel k occupies `[k*WIDTH +: WIDTH]`.
- `update_req` input, 1: one-cycle pulse that snapshots `duty` into the shadow registers.
- `update_done` output, 1: one-cycle pulse when shadow values become active.
- `period_start` output, 1: one-cycle pulse at each period boundary.
- `pwm_out` output, `N_CH`: registered PWM outputs.

## Operation
- **Prescaler.** Counts 0..P. It asserts `tick` on the cycle where the count equals P, then wraps to 0. P=0 gives a tick every clock.
- **Edge mode counter.** The sequence is 0,1,…,M−1, then wraps to 0. The period is M ticks.
- **Center mode counter.** The sequence is 0,1,…,M−1,M−1,…,1,0; every value occurs twice. A direction bit flips at each end. The period is 2M ticks.
- **Period boundary.** Occurs on the tick that loads count 0 with direction up.
  - `mode` and `prescale` are latched into working copies here.
  - A change on either input mid-period has no effect until the next boundary.
- **Compare.** `pwm_out[k]` is the registered value of (count < active_duty[k]).
  - duty=0 keeps the output constantly low.
  - duty=M keeps the output constantly high.
  - High time is duty ticks in edge mode and 2·duty ticks in center mode. In center mode the pulse is centered on the period boundary.
- **Shadow/update.**
  - `update_req` copies `duty` into the shadow registers and sets `pending`.
  - At the next boundary with `pending` set, shadow is copied to active, `pending` clears, and `update_done` pulses.
- **Boundary cases for updates.**
  - A second `update_req` while pending overwrites the shadow. Only one `update_done` pulse results.
  - An `update_req` in the same cycle as a boundary is captured into the shadow but applied at the following boundary.
- **Disabled (`ena`=0).**
  - Prescaler, counter and direction are held at 0, and `pwm_out` is 0.
  - `update_req` copies `duty` straight to both shadow and active. `update_done` pulses the next cycle and `pending` stays clear.
- **Enable rising.**
  - The working `mode` and `prescale` copies load on the first cycle with `ena`=1.
  - The period starts at count 0, and `period_start` pulses on that first cycle.

## Timing
- Reset values: all outputs 0, counters 0, direction up, shadow and active duties 0, `pending` 0.
- Reset acts immediately on assertion; no clock is needed.
- Output latency: `pwm_out` lags the counter value by 1 clk.
- `period_start` coincides with the cycle the counter reads 0 at the start of a period.
- `update_done` asserts in the same cycle as the `period_start` pulse at which active duties change. The new duty is visible on `pwm_out` 1 clk later.
- Period length in clocks is M·(P+1) in edge mode and 2M·(P+1) in center mode.

## Structure
- Constants and typedefs in `toi2s_pkg`:
  - `pwm_mode_t` enum with values `PWM_EDGE` and `PWM_CENTER`.
  - Register-bank field widths for `mode`, `prescale` and the duty fields, added to the `sys_cfg` struct.
- Sub-module `pwm_timebase`:
  - Contains the prescaler, counter and direction bit, plus latching of the working `mode` and `prescale` copies.
  - Outputs `count` and a `boundary` strobe.
- Per-channel shadow, active and compare logic sits in a generate loop in `pwm_multi_ch`.

## Test plan
All scenarios use `WIDTH`=4 (M=15) and `N_CH`=2.
- **Reset.** Assert `resetb`=0 mid-period with `ena`=1 → `pwm_out`=0 immediately; after release with `ena`=0, all outputs stay 0.
- **Edge mode.** P=0, duties {5, 15} → ch0 is high 5 of every 15 clocks, ch1 is constantly high, and `period_start` pulses every 15 clocks.
- **Center mode.** P=1, duty ch0=3 → ch0 is high 12 clocks per 60-clock period, symmetric about `period_start`; duty ch1=0 → ch1 is never high.
- **Mid-period update.** Edge mode, duty 5, `update_req` with 10 at count 7 → the current period keeps duty 5, `update_done` pulses at the next boundary, and the following period shows 10 high clocks.
- **Update on boundary.** `update_req` on a `period_start` cycle → applied one period later with exactly one `update_done` pulse. Two requests in one period → the last value wins and one `update_done` pulse results.
- **Mode change while running.** Toggle `mode` mid-period → takes effect at the next boundary, with no runt pulse in the current period.
